div_rr_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one 16-bit divider core among NREQ requesters.

---
 rtl/div_rr_arbiter_if.sv | 38 +++
 rtl/div_rr_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/div_rr_arbiter_if.sv
// Requester and divider-side bundle for the shared divider arbiter.
// Ports: requester Req/operands/Grant/Done/results/error flags; divider DvdReset/Start/operands/Ready/results.
interface div_rr_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]    Req;
   logic [NREQ*16-1:0] DividendIn;
   logic [NREQ*16-1:0] DivisorIn;
   logic [NREQ-1:0]    Grant;
   logic [NREQ-1:0]    Done;
   logic [15:0]        QuotientOut;
   logic [15:0]        RemainderOut;
   logic               DivZeroErr;
   logic               TimeoutErr;
   logic               DvdReset;
   logic               Start;
   logic [15:0]        Dividend;
   logic [15:0]        Divisor;
   logic               Ready;
   logic [15:0]        Quotient;
   logic [15:0]        Remainder;

   modport master (
      input  Req, DividendIn, DivisorIn,
      output Grant, Done, QuotientOut, RemainderOut,
      output DivZeroErr, TimeoutErr,
      output DvdReset, Start, Dividend, Divisor,
      input  Ready, Quotient, Remainder
   );

   modport slave (
      output Req, DividendIn, DivisorIn,
      input  Grant, Done, QuotientOut, RemainderOut,
      input  DivZeroErr, TimeoutErr,
      input  DvdReset, Start, Dividend, Divisor,
      output Ready, Quotient, Remainder
   );
endinterface

// File: rtl/div_rr_arbiter.sv
// Round-robin sequencer sharing one 16-bit divider among NREQ requesters.
// Ports: clk, reset (sync, active-high), bus (master side of div_rr_arbiter_if).
module div_rr_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input logic              clk,
   input logic              reset,
   div_rr_arbiter_if.master bus
);

   localparam int IW = $clog2(NREQ);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_RSTDVD,
      S_START,
      S_WAIT,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [15:0]     dvd_q, dvd_d;
   logic [15:0]     dvs_q, dvs_d;
   logic [15:0]     quo_q, quo_d;
   logic [15:0]     rem_q, rem_d;
   logic            dz_q, dz_d;
   logic            to_q, to_d;

   logic            any_req;
   logic [IW-1:0]   win;
   logic [NREQ-1:0] idx_oh;

   // Two passes: indices at/above ptr first, then the wrapped-around low ones.
   always_comb begin
      any_req = 1'b0;
      win     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!any_req && bus.Req[i] && i >= int'(ptr_q)) begin
            any_req = 1'b1;
            win     = IW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!any_req && bus.Req[i]) begin
            any_req = 1'b1;
            win     = IW'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      tcnt_d  = tcnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      to_d    = to_q;
      unique case (state_q)
         S_IDLE: begin
            dz_d = 1'b0;
            to_d = 1'b0;
            if (any_req) begin
               idx_d   = win;
               dvd_d   = bus.DividendIn[{win, 4'b0000} +: 16];
               dvs_d   = bus.DivisorIn[{win, 4'b0000} +: 16];
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (dvs_q == 16'd0) begin
               dz_d    = 1'b1;
               quo_d   = 16'hFFFF;
               rem_d   = dvd_q;
               state_d = S_DONE;
            end else begin
               state_d = S_RSTDVD;
            end
         end
         S_RSTDVD: begin
            tcnt_d  = '0;
            state_d = S_START;
         end
         S_START: begin
            tcnt_d = tcnt_q + TW'(1);
            if (!bus.Ready) begin
               state_d = S_WAIT;
            end else if (tcnt_q == TMAX) begin
               to_d    = 1'b1;
               quo_d   = '0;
               rem_d   = '0;
               state_d = S_DONE;
            end
         end
         S_WAIT: begin
            tcnt_d = tcnt_q + TW'(1);
            // Completion takes priority over a coincident timeout.
            if (bus.Ready) begin
               quo_d   = bus.Quotient;
               rem_d   = bus.Remainder;
               state_d = S_DONE;
            end else if (tcnt_q == TMAX) begin
               to_d    = 1'b1;
               quo_d   = '0;
               rem_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
            dz_d    = 1'b0;
            to_d    = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         tcnt_q  <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         tcnt_q  <= tcnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         to_q    <= to_d;
      end
   end

   assign idx_oh = NREQ'(1) << idx_q;

   assign bus.Grant        = (state_q != S_IDLE) ? idx_oh : '0;
   assign bus.Done         = (state_q == S_DONE) ? idx_oh : '0;
   assign bus.DvdReset     = (state_q == S_RSTDVD);
   assign bus.Start        = (state_q == S_START);
   assign bus.Dividend     = dvd_q;
   assign bus.Divisor      = dvs_q;
   assign bus.QuotientOut  = quo_q;
   assign bus.RemainderOut = rem_q;
   assign bus.DivZeroErr   = dz_q;
   assign bus.TimeoutErr   = to_q;

endmodule
